// File: rtl/alu_input_sequencer_if.sv
// Button inputs and load-strobe/LED outputs of the ALU input sequencer.
// The master drives the buttons; the slave (the sequencer) drives the strobes.
interface alu_input_sequencer_if;
   logic       btn_enter;
   logic       btn_undo;
   logic       load_A;
   logic       load_B;
   logic       load_Op;
   logic       updateRes;
   logic [3:0] state_leds;

   modport master (
      output btn_enter, btn_undo,
      input  load_A, load_B, load_Op, updateRes, state_leds
   );

   modport slave (
      input  btn_enter, btn_undo,
      output load_A, load_B, load_Op, updateRes, state_leds
   );
endinterface

// File: rtl/alu_input_sequencer.sv
// ENTER/UNDO button sequencer emitting one-cycle ALU load strobes A -> B -> Op -> result.
// Latency press->strobe: 2 sync + DB_CYCLES debounce + 1 edge + 1 register; no backpressure.
module alu_input_sequencer #(
   parameter int DB_CYCLES = 500000
) (
   input  logic                 clk,
   input  logic                 reset,
   alu_input_sequencer_if.slave ui
);
   localparam int              CW       = $clog2(DB_CYCLES) + 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CYCLES - 1);

   localparam logic [2:0] WAIT_A  = 3'd0;
   localparam logic [2:0] WAIT_B  = 3'd1;
   localparam logic [2:0] WAIT_OP = 3'd2;
   localparam logic [2:0] CALC    = 3'd3;
   localparam logic [2:0] SHOW    = 3'd4;

   // Bit 0 = ENTER, bit 1 = UNDO throughout the conditioning path.
   logic [1:0]    btn_raw;
   logic [1:0]    sync1;
   logic [1:0]    sync2;
   logic [1:0]    db;
   logic [1:0]    db_d;
   logic [1:0]    settle;
   logic [1:0]    armed;
   logic [1:0]    evt;
   logic [CW-1:0] cnt [2];

   logic       enter_evt;
   logic       undo_evt;
   logic [2:0] state;
   logic       load_a_q;
   logic       load_b_q;
   logic       load_op_q;
   logic       update_res_q;
   logic [3:0] leds;

   assign btn_raw = {ui.btn_undo, ui.btn_enter};

   // A button only becomes armed once it is seen released after the synchroniser has
   // refilled, so a button held through reset cannot produce a rising-edge event.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1  <= '0;
         sync2  <= '0;
         db     <= '0;
         db_d   <= '0;
         settle <= '0;
         armed  <= '0;
         evt    <= '0;
         for (int i = 0; i < 2; i++) cnt[i] <= '0;
      end else begin
         sync1  <= btn_raw;
         sync2  <= sync1;
         settle <= {settle[0], 1'b1};
         db_d   <= db;
         for (int i = 0; i < 2; i++) begin
            armed[i] <= armed[i] | (settle[1] & ~sync2[i]);
            evt[i]   <= db[i] & ~db_d[i] & armed[i];
            if (sync2[i] == db[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               db[i]  <= sync2[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   assign enter_evt = evt[0];
   assign undo_evt  = evt[1];

   // ENTER is tested first everywhere, so a coincident UNDO is dropped.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= WAIT_A;
         load_a_q     <= 1'b0;
         load_b_q     <= 1'b0;
         load_op_q    <= 1'b0;
         update_res_q <= 1'b0;
      end else begin
         load_a_q     <= 1'b0;
         load_b_q     <= 1'b0;
         load_op_q    <= 1'b0;
         update_res_q <= 1'b0;
         case (state)
            WAIT_A: begin
               if (enter_evt) begin
                  state    <= WAIT_B;
                  load_a_q <= 1'b1;
               end
            end
            WAIT_B: begin
               if (enter_evt) begin
                  state    <= WAIT_OP;
                  load_b_q <= 1'b1;
               end else if (undo_evt) begin
                  state <= WAIT_A;
               end
            end
            WAIT_OP: begin
               if (enter_evt) begin
                  state     <= CALC;
                  load_op_q <= 1'b1;
               end else if (undo_evt) begin
                  state <= WAIT_B;
               end
            end
            CALC: begin
               state        <= SHOW;
               update_res_q <= 1'b1;
            end
            SHOW: begin
               if (enter_evt) begin
                  state <= WAIT_A;
               end else if (undo_evt) begin
                  state <= WAIT_OP;
               end
            end
            default: state <= WAIT_A;
         endcase
      end
   end

   always_comb begin
      leds = 4'b1000;
      case (state)
         WAIT_A:  leds = 4'b0001;
         WAIT_B:  leds = 4'b0010;
         WAIT_OP: leds = 4'b0100;
         default: leds = 4'b1000;
      endcase
   end

   assign ui.load_A     = load_a_q;
   assign ui.load_B     = load_b_q;
   assign ui.load_Op    = load_op_q;
   assign ui.updateRes  = update_res_q;
   assign ui.state_leds = leds;
endmodule
